// File: rtl/instfetch.sv
`default_nettype none
// ============================================================================
//  Module      : instfetch
//  Description : Instruction fetch stage. Holds the PC, presents it to a
//                combinational instruction ROM and buffers fetched words in a
//                two-entry in-order queue toward the decode stage. Supports
//                branch redirect and halt.
//  Revision    : 1.0 - initial release
// ============================================================================
module instfetch #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 17,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [BUS_WIDTH-1:0]  adr,
    input  logic [DATA_WIDTH-1:0] readdata,
    input  logic                  branch_taken,
    input  logic [BUS_WIDTH-1:0]  branch_target,
    input  logic                  halt_req,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [BUS_WIDTH-1:0]  out_pc
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [BUS_WIDTH-1:0] c_RESET_PC   = BUS_WIDTH'(RESET_PC);
    localparam logic [BUS_WIDTH-1:0] c_PC_STEP    = BUS_WIDTH'(4);
    // Low two address bits are cleared on redirect so fetch stays word aligned.
    localparam logic [BUS_WIDTH-1:0] c_ALIGN_MASK = BUS_WIDTH'(3);
    localparam logic [1:0]           c_QUEUE_DEPTH = 2'd2;

    // ------------------------------------------------------------------
    // Fetch state machine encoding
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------
    // Datapath storage
    // ------------------------------------------------------------------
    logic [BUS_WIDTH-1:0]  r_pc;
    logic [1:0]            r_count;

    // Entry 0 is always the head; entry 1 only holds data when count == 2.
    logic [DATA_WIDTH-1:0] r_q0_instr;
    logic [BUS_WIDTH-1:0]  r_q0_pc;
    logic [DATA_WIDTH-1:0] r_q1_instr;
    logic [BUS_WIDTH-1:0]  r_q1_pc;

    logic                  w_push;
    logic                  w_pop;
    logic [BUS_WIDTH-1:0]  w_pc_inc;
    logic [BUS_WIDTH-1:0]  w_target_aligned;

    // ------------------------------------------------------------------
    // Combinational datapath helpers
    // ------------------------------------------------------------------
    // The adder is exactly BUS_WIDTH wide, so the carry out is dropped and
    // the PC wraps naturally from the top of the ROM back to zero.
    assign w_pc_inc         = r_pc + c_PC_STEP;
    assign w_target_aligned = branch_target & ~c_ALIGN_MASK;

    assign adr       = r_pc;
    assign out_valid = (r_count != 2'd0);
    assign out_instr = r_q0_instr;
    assign out_pc    = r_q0_pc;

    // State register; reset returns fetch to the running state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and push/pop decisions; branch overrides halt and both queue ops.
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_pop        = 1'b0;

        if (branch_taken) begin
            // Redirect flushes everything, so neither queue operation is taken.
            w_state_next = ST_RUN;
        end else begin
            w_pop = out_valid & out_ready;
            case (r_state)
                ST_RUN: begin
                    if (halt_req) begin
                        w_state_next = ST_HALTED;
                    end else begin
                        // A full queue never pushes, even if it pops this
                        // cycle; the freed slot is refilled next cycle.
                        w_push = (r_count < c_QUEUE_DEPTH);
                    end
                end
                ST_HALTED: begin
                    w_state_next = ST_HALTED;
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    // PC register: redirect, advance on push, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= c_RESET_PC;
        end else if (branch_taken) begin
            r_pc <= w_target_aligned;
        end else if (w_push) begin
            r_pc <= w_pc_inc;
        end
    end

    // Queue occupancy and entries; head shifts forward on pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= 2'd0;
            r_q0_instr <= '0;
            r_q0_pc    <= '0;
            r_q1_instr <= '0;
            r_q1_pc    <= '0;
        end else if (branch_taken) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_q0_instr <= readdata;
                        r_q0_pc    <= r_pc;
                    end else begin
                        r_q1_instr <= readdata;
                        r_q1_pc    <= r_pc;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_q0_instr <= r_q1_instr;
                    r_q0_pc    <= r_q1_pc;
                    r_count    <= r_count - 2'd1;
                end
                2'b11: begin
                    // Push implies count < 2 and pop implies count > 0, so
                    // exactly one entry is present: the new word becomes head.
                    r_q0_instr <= readdata;
                    r_q0_pc    <= r_pc;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instfetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instfetch
//  Description : Directed self-checking bench for instfetch with a small
//                combinational ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instfetch;

    localparam int DATA_WIDTH = 32;
    localparam int BUS_WIDTH  = 17;

    logic                  clk;
    logic                  reset;
    logic [BUS_WIDTH-1:0]  adr;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  branch_taken;
    logic [BUS_WIDTH-1:0]  branch_target;
    logic                  halt_req;
    logic                  out_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [BUS_WIDTH-1:0]  out_pc;

    int n_tests;
    int n_fail;

    instfetch #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .RESET_PC   (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .adr           (adr),
        .readdata      (readdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    // ROM contents: three fixed words, everything else tagged with its address.
    function automatic logic [31:0] rom(input logic [BUS_WIDTH-1:0] a);
        case (a)
            17'h00000: rom = 32'h20030000;
            17'h00004: rom = 32'h20040014;
            17'h00018: rom = 32'ha00300ff;
            default:   rom = 32'h5A000000 | 32'(a);
        endcase
    endfunction

    assign readdata = rom(adr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        branch_taken  = 1'b0;
        branch_target = '0;
        halt_req      = 1'b0;
        out_ready     = 1'b1;

        // Reset state
        #2;
        chk("rst_adr",   32'(adr), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc",    32'(out_pc), 32'h0);
        #1 reset = 1'b0;

        // Basic streaming with consumer always ready
        tick();
        chk("e1_valid", 32'(out_valid), 32'h1);
        chk("e1_instr", out_instr, 32'h20030000);
        chk("e1_pc",    32'(out_pc), 32'h0);
        chk("e1_adr",   32'(adr), 32'h4);
        tick();
        chk("e2_instr", out_instr, 32'h20040014);
        chk("e2_pc",    32'(out_pc), 32'h4);
        chk("e2_adr",   32'(adr), 32'h8);

        // Fill the queue, then reset asynchronously between edges
        out_ready = 1'b0;
        tick();
        chk("e3_pc",  32'(out_pc), 32'h4);
        chk("e3_adr", 32'(adr), 32'hC);
        tick();
        chk("e4_full_adr", 32'(adr), 32'hC);
        chk("e4_full_pc",  32'(out_pc), 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'h0);
        chk("async_adr",   32'(adr), 32'h0);
        chk("async_pc",    32'(out_pc), 32'h0);
        #1 reset = 1'b0;

        // Back-pressure from reset, then release in order
        tick();
        chk("bp1_pc",  32'(out_pc), 32'h0);
        chk("bp1_adr", 32'(adr), 32'h4);
        tick();
        chk("bp2_adr", 32'(adr), 32'h8);
        chk("bp2_pc",  32'(out_pc), 32'h0);
        tick();
        chk("bp3_hold_adr", 32'(adr), 32'h8);
        chk("bp3_hold_pc",  32'(out_pc), 32'h0);
        out_ready = 1'b1;
        tick();
        chk("rel1_pc",    32'(out_pc), 32'h4);
        chk("rel1_instr", out_instr, 32'h20040014);
        chk("rel1_adr",   32'(adr), 32'h8);
        tick();
        chk("rel2_pc",    32'(out_pc), 32'h8);
        chk("rel2_instr", out_instr, 32'h5A000008);
        chk("rel2_adr",   32'(adr), 32'hC);

        // Branch while the queue is full
        out_ready = 1'b0;
        tick();
        chk("bf_pc",  32'(out_pc), 32'h8);
        chk("bf_adr", 32'(adr), 32'h10);
        branch_taken  = 1'b1;
        branch_target = 17'h0001B;
        tick();
        chk("br_valid", 32'(out_valid), 32'h0);
        chk("br_adr",   32'(adr), 32'h18);
        branch_taken = 1'b0;
        out_ready    = 1'b1;
        tick();
        chk("br1_valid", 32'(out_valid), 32'h1);
        chk("br1_instr", out_instr, 32'ha00300ff);
        chk("br1_pc",    32'(out_pc), 32'h18);
        chk("br1_adr",   32'(adr), 32'h1C);

        // PC wrap at the top of the address space
        branch_taken  = 1'b1;
        branch_target = 17'h1FFFF;
        tick();
        chk("wr_adr",   32'(adr), 32'h1FFFC);
        chk("wr_valid", 32'(out_valid), 32'h0);
        branch_taken = 1'b0;
        tick();
        chk("wr1_pc",    32'(out_pc), 32'h1FFFC);
        chk("wr1_instr", out_instr, 32'h5A01FFFC);
        chk("wr1_adr",   32'(adr), 32'h0);
        tick();
        chk("wr2_pc",    32'(out_pc), 32'h0);
        chk("wr2_instr", out_instr, 32'h20030000);

        // Halt with one entry: drains, PC frozen
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("h1_valid", 32'(out_valid), 32'h0);
        chk("h1_adr",   32'(adr), 32'h4);
        tick();
        tick();
        chk("h3_valid", 32'(out_valid), 32'h0);
        chk("h3_adr",   32'(adr), 32'h4);
        branch_taken  = 1'b1;
        branch_target = 17'h00004;
        tick();
        branch_taken = 1'b0;
        chk("hb_adr",   32'(adr), 32'h4);
        chk("hb_valid", 32'(out_valid), 32'h0);
        tick();
        chk("hr_valid", 32'(out_valid), 32'h1);
        chk("hr_pc",    32'(out_pc), 32'h4);
        chk("hr_instr", out_instr, 32'h20040014);

        // Halt with a full queue: no pushes, pops continue until empty
        out_ready = 1'b0;
        tick();
        chk("hf_adr", 32'(adr), 32'hC);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("hf1_adr", 32'(adr), 32'hC);
        chk("hf1_pc",  32'(out_pc), 32'h4);
        out_ready = 1'b1;
        tick();
        chk("hd1_pc",    32'(out_pc), 32'h8);
        chk("hd1_valid", 32'(out_valid), 32'h1);
        chk("hd1_adr",   32'(adr), 32'hC);
        tick();
        chk("hd2_valid", 32'(out_valid), 32'h0);
        chk("hd2_adr",   32'(adr), 32'hC);
        tick();
        chk("hd3_valid", 32'(out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instfetch.md
INSTFETCH -- requirements
Module: instfetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter BUS_WIDTH, default 17, byte-address width of the instruction ROM.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port adr  output  BUS_WIDTH  byte address presented to the instruction ROM.
REQ-007 SHALL have port readdata  input  DATA_WIDTH  combinational ROM data for adr, valid in the same cycle.
REQ-008 SHALL have port branch_taken  input  1  redirect request from downstream.
REQ-009 SHALL have port branch_target  input  BUS_WIDTH  redirect byte address.
REQ-010 SHALL have port halt_req  input  1  stop-fetch request.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the head entry this cycle.
REQ-012 SHALL have port out_valid  output  1  head entry present.
REQ-013 SHALL have port out_instr  output  DATA_WIDTH  head instruction word.
REQ-014 SHALL have port out_pc  output  BUS_WIDTH  byte address of the head instruction.

Function
REQ-015 SHALL hold a PC register; adr SHALL equal PC combinationally.
REQ-016 SHALL have a 2-entry in-order queue of {instr, pc}; out_valid = (count != 0); out_instr/out_pc driven from the head.
REQ-017 SHALL have FSM states RUN and HALTED.
REQ-018 push = (state == RUN) and (count < 2) and not branch_taken; on push, queue tail captures {readdata, PC} and PC advances by 4.
REQ-019 pop = out_valid and out_ready; on pop the head entry is removed.
REQ-020 SHALL support push and pop in the same cycle; count unchanged; order preserved.
REQ-021 At count == 2 with no pop, SHALL NOT push and SHALL hold PC; at count == 2 with pop, still no push (a new push happens the following cycle).
REQ-022 PC + 4 SHALL wrap modulo 2^BUS_WIDTH (0x1FFFC -> 0x00000).
REQ-023 branch_taken SHALL have highest priority: next cycle count = 0, PC = branch_target with bits [1:0] forced to 0, state = RUN; any concurrent push/pop is discarded.
REQ-024 halt_req high in RUN (without branch_taken) SHALL move to HALTED next cycle; no push that cycle.
REQ-025 In HALTED, SHALL NOT push, SHALL hold PC, and SHALL still allow pops until empty; only branch_taken or reset leaves HALTED.
REQ-026 Latency: an instruction at PC is visible on out_* the cycle after it is pushed.

Reset
REQ-027 While reset is high, SHALL force PC = RESET_PC, count = 0, state = RUN, out_valid = 0, out_instr = 0, out_pc = 0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard queue contents; the first push after deassertion SHALL be from RESET_PC.

Verification
REQ-029 Reset, ROM at 0x0=0x20030000, 0x4=0x20040014, out_ready=1 -> adr=0x00000 during reset; after 1st edge out_valid=1, out_instr=0x20030000, out_pc=0x0; after 2nd edge out_instr=0x20040014, out_pc=0x4.
REQ-030 out_ready=0 from reset -> after 2 edges count=2, adr=0x00008 held; raise out_ready -> heads 0x0, 0x4, 0x8 in order, no gaps or duplicates.
REQ-031 branch_taken=1 with branch_target=0x1B while queue full -> next cycle out_valid=0, adr=0x00018; following cycle out_instr=0xa00300ff, out_pc=0x18.
REQ-032 PC=0x1FFFC, out_ready=1 -> push 0x1FFFC then adr=0x00000 (wrap).
REQ-033 halt_req pulse with count=1, out_ready=1 -> PC frozen, queue drains to out_valid=0; branch_taken to 0x4 resumes fetch, out_pc=0x4.
REQ-034 Assert reset asynchronously between edges with count=2 -> out_valid=0 and adr=RESET_PC immediately, before the next clk edge.
